// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the two-requester UART transmit arbiter.
// Optional watchdog macro: UART_TX_ARB_TIMEOUT_EN (see uart_tx_arbiter).
package uart_tx_arb_pkg;

    localparam int unsigned NUM_REQ         = 2;
    localparam int unsigned DATA_W          = 8;
    localparam int unsigned TIMER_W         = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    // One byte offered by a requester, with its end-of-packet marker.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    // Requester index to one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/uart_tx_arb_timer.sv
// Watchdog counter for the arbiter's WAIT state.
// Ports:
//   clk, rst   : clock, async active-high reset
//   load       : clear the count (asserted the cycle before WAIT)
//   en         : count this cycle (asserted while in WAIT)
//   limit      : number of counted cycles that constitutes expiry (>= 1)
//   expired_c  : combinational, high in the counted cycle that reaches limit
module uart_tx_arb_timer
    import uart_tx_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [TIMER_W-1:0] limit,
    output logic               expired_c
);

    logic [TIMER_W-1:0] count;

    // count holds the number of already-completed WAIT cycles, so the
    // current cycle is the limit-th one when count == limit - 1.
    assign expired_c = en && (count == limit - TIMER_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en && !expired_c) begin
            count <= count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter between
// two valid/ready byte streams.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN enables a watchdog that
// aborts a byte whose tx_done never arrives (timeout_err tied 0 otherwise).
// Ports:
//   clk, rst                  : clock, async active-high reset
//   req{0,1}_data/valid/last  : requester byte streams
//   req{0,1}_ready            : combinational accept for each requester
//   tx_data, tx_wr            : byte and one-cycle write strobe to the UART
//   tx_done                   : byte-sent pulse from the UART
//   grant                     : one-hot owner, 00 when idle
//   busy                      : FSM not idle
//   timeout_err               : one-cycle pulse on watchdog abort
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_valid,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_valid,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_wr,
    input  logic              tx_done,
    output logic [NUM_REQ-1:0] grant,
    output logic              busy,
    output logic              timeout_err
);

    state_t               state, state_d;
    logic                 owner, owner_d;
    logic                 last_grant, last_grant_d;
    logic                 cap_last, cap_last_d;
    logic [DATA_W-1:0]    data_d;
    logic [NUM_REQ-1:0]   grant_d;
    logic                 tx_wr_d, busy_d, timeout_d;
    logic [NUM_REQ-1:0]   ready_c;
    logic [NUM_REQ-1:0]   valid;
    logic                 win;
    logic                 expired_c;
    beat_t                beat [NUM_REQ];

    assign valid   = {req1_valid, req0_valid};
    assign beat[0] = '{last: req0_last, data: req0_data};
    assign beat[1] = '{last: req1_last, data: req1_data};

    // Round-robin pick: on contention the requester that did not finish the
    // previous packet wins; a lone requester always wins.
    assign win = (valid[0] && valid[1]) ? ~last_grant : valid[1];

    // Ready is masked during reset so nothing is accepted while held.
    assign req0_ready = ready_c[0] & ~rst;
    assign req1_ready = ready_c[1] & ~rst;

`ifdef UART_TX_ARB_TIMEOUT_EN
    // Watchdog: cleared while in SEND, counts WAIT cycles.
    uart_tx_arb_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (state == SEND),
        .en        (state == WAIT),
        .limit     (TIMER_W'(TIMEOUT_CYCLES)),
        .expired_c (expired_c)
    );
`else
    logic unused_timeout;
    assign expired_c      = 1'b0;
    assign unused_timeout = ^TIMER_W'(TIMEOUT_CYCLES);
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_grant_d = last_grant;
        cap_last_d   = cap_last;
        data_d       = tx_data;
        timeout_d    = 1'b0;
        ready_c      = '0;

        unique case (state)
            IDLE: begin
                if (|valid) begin
                    owner_d    = win;
                    ready_c    = req_onehot(win);
                    data_d     = beat[win].data;
                    cap_last_d = beat[win].last;
                    state_d    = SEND;
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A real tx_done takes precedence over a same-cycle expiry.
                if (tx_done) begin
                    if (cap_last) begin
                        state_d      = IDLE;
                        last_grant_d = owner;
                    end else begin
                        state_d = HOLD;
                    end
                end else if (expired_c) begin
                    state_d      = IDLE;
                    last_grant_d = owner;
                    timeout_d    = 1'b1;
                end
            end
            HOLD: begin
                if (valid[owner]) begin
                    ready_c    = req_onehot(owner);
                    data_d     = beat[owner].data;
                    cap_last_d = beat[owner].last;
                    state_d    = SEND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_wr_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        grant_d = busy_d ? req_onehot(owner_d) : '0;
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            cap_last    <= 1'b0;
            tx_data     <= '0;
            tx_wr       <= 1'b0;
            grant       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            owner       <= owner_d;
            last_grant  <= last_grant_d;
            cap_last    <= cap_last_d;
            tx_data     <= data_d;
            tx_wr       <= tx_wr_d;
            grant       <= grant_d;
            busy        <= busy_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, hand-written
// corner sequences, and a randomized run against a packet-level model.
module tb_uart_tx_arbiter;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 50;
`else
    localparam int unsigned TB_TIMEOUT = 65535;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req0_data, req1_data;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] tx_data;
    logic       tx_wr, tx_done;
    logic [1:0] grant;
    logic       busy, timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_done    (tx_done),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh(input int k);
        return (k == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic clear_inputs();
        req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
        tx_done    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Cycles spent in WAIT: no strobe, stable grant, nobody ready.
    task automatic wait_window(input int n, input logic [1:0] g, input string tag);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (tx_wr !== 1'b0 || grant !== g || req0_ready || req1_ready) bad++;
        end
        chk(tag, bad, 0);
    endtask

    typedef struct {
        logic       v0, v1;
        logic [7:0] d0, d1;
        logic [1:0] exp_rdy;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] pk [3];

    // Randomized-phase storage and packet-level model state.
    logic [7:0] rd [2][64];
    logic       rl [2][64];
    int         len [2];
    int         head [2];
    logic [1:0] vld, exp_rdy, rdy;
    int         open_k, last_owner, exp_src, done_cnt, pl, bad;
    bit         busy_byte, wr_due, idle_due, exp_last, finished;
    logic [7:0] exp_data;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();

        // Reset values, with a valid offered while reset is held.
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        chk("reset tx_wr", tx_wr, 0);
        chk("reset grant", grant, 0);
        chk("reset busy", busy, 0);
        chk("reset timeout_err", timeout_err, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset ready0 masked", req0_ready, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Three-byte packet from req0, tx_done 100 cycles after each strobe;
        // req1 waits throughout and must not be readied mid-packet.
        pk[0] = 8'h11; pk[1] = 8'h22; pk[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_done    = 1'b0;
            req0_valid = 1'b1;
            req0_data  = pk[i];
            req0_last  = (i == 2);
            #1;
            chk($sformatf("pkt ready0 b%0d", i), req0_ready, 1);
            chk($sformatf("pkt ready1 b%0d", i), req1_ready, 0);
            @(negedge clk);
            req0_valid = 1'b0;
            chk($sformatf("pkt tx_wr b%0d", i), tx_wr, 1);
            chk($sformatf("pkt tx_data b%0d", i), tx_data, pk[i]);
            chk($sformatf("pkt grant b%0d", i), grant, 2'b01);
            if (i == 0) begin
                req1_valid = 1'b1; req1_data = 8'h77; req1_last = 1'b1;
            end
            #1;
            chk($sformatf("pkt ready1 send b%0d", i), req1_ready, 0);
            wait_window(99, 2'b01, $sformatf("pkt wait window b%0d", i));
            @(negedge clk);
            tx_done = 1'b1;
            if (i < 2) begin
                req0_valid = 1'b1; req0_data = pk[i+1]; req0_last = (i + 1 == 2);
            end
            #1;
            chk($sformatf("pkt ready0 done cycle b%0d", i), req0_ready, 0);
            chk($sformatf("pkt grant done cycle b%0d", i), grant, 2'b01);
        end
        @(negedge clk);
        tx_done = 1'b0;
        chk("pkt idle busy", busy, 0);
        chk("pkt idle grant", grant, 0);
        #1;
        chk("pkt req1 after packet", {req1_ready, req0_ready}, 2'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("pkt req1 tx_wr", tx_wr, 1);
        chk("pkt req1 tx_data", tx_data, 8'h77);
        chk("pkt req1 grant", grant, 2'b10);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("pkt req1 done idle", {busy, grant}, 0);

        // tx_done glitches in IDLE and in SEND are ignored.
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("idle glitch", {tx_wr, busy, grant}, 0);
        req0_valid = 1'b1; req0_data = 8'hC3; req0_last = 1'b1;
        #1;
        chk("glitch ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        tx_done    = 1'b1;
        chk("glitch tx_wr", tx_wr, 1);
        @(negedge clk);
        tx_done = 1'b0;
        chk("send glitch no extra wr", tx_wr, 0);
        chk("send glitch still busy", busy, 1);
        wait_window(3, 2'b01, "send glitch wait");
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("send glitch real done", busy, 0);

        // Directed arbitration table, single-byte packets, from reset.
        vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h5A, 2'b01, 8'hA5};
        vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h5A, 2'b10, 8'h5A};
        vecs[2] = '{1'b1, 1'b1, 8'h33, 8'h44, 2'b01, 8'h33};
        vecs[3] = '{1'b0, 1'b1, 8'h55, 8'h66, 2'b10, 8'h66};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h77, 2'b10, 8'h77};
        vecs[5] = '{1'b1, 1'b0, 8'h88, 8'h00, 2'b01, 8'h88};
        vecs[6] = '{1'b1, 1'b0, 8'h99, 8'h00, 2'b01, 8'h99};
        vecs[7] = '{1'b1, 1'b1, 8'hAA, 8'hBB, 2'b10, 8'hBB};
        vecs[8] = '{1'b1, 1'b1, 8'hCC, 8'hDD, 2'b01, 8'hCC};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_data = vecs[i].d0; req0_last = 1'b1;
            req1_valid = vecs[i].v1; req1_data = vecs[i].d1; req1_last = 1'b1;
            #1;
            chk($sformatf("vec%0d ready", i), {req1_ready, req0_ready}, vecs[i].exp_rdy);
            @(negedge clk);
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk($sformatf("vec%0d tx_wr", i), tx_wr, 1);
            chk($sformatf("vec%0d tx_data", i), tx_data, vecs[i].exp_data);
            chk($sformatf("vec%0d grant", i), grant, vecs[i].exp_rdy);
            @(negedge clk);
            tx_done = 1'b1;
            chk($sformatf("vec%0d busy", i), busy, 1);
            @(negedge clk);
            tx_done = 1'b0;
            chk($sformatf("vec%0d idle", i), {busy, grant}, 0);
        end

        // Reset in the middle of WAIT drops the packet; req0 first afterwards.
        do_reset();
        @(negedge clk);
        req1_valid = 1'b1; req1_data = 8'hE1; req1_last = 1'b0;
        #1;
        chk("rstwait ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("rstwait tx_wr", tx_wr, 1);
        chk("rstwait grant", grant, 2'b10);
        @(negedge clk);
        chk("rstwait in wait", {busy, grant}, 3'b110);
        rst = 1'b1;
        req0_valid = 1'b1; req0_data = 8'h0F; req0_last = 1'b1;
        req1_valid = 1'b1; req1_data = 8'hE2; req1_last = 1'b1;
        #1;
        chk("rstwait async tx_wr", tx_wr, 0);
        chk("rstwait async grant", grant, 0);
        chk("rstwait async busy", busy, 0);
        chk("rstwait async ready", {req1_ready, req0_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("rstwait no wr after reset", tx_wr, 0);
        #1;
        chk("rstwait req0 priority", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("rstwait req0 data", tx_data, 8'h0F);
        chk("rstwait req0 grant", grant, 2'b01);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        #1;
        chk("rstwait req1 next", {req1_ready, req0_ready}, 2'b10);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("rstwait req1 data", tx_data, 8'hE2);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog abort after 50 WAIT cycles; pending req1 granted next.
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_data = 8'hAB; req0_last = 1'b0;
        #1;
        chk("timeout ready0", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = 8'hCD; req1_last = 1'b1;
        chk("timeout tx_wr", tx_wr, 1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            #1;
            if (timeout_err || grant !== 2'b01 || req1_ready) bad++;
        end
        chk("timeout early", bad, 0);
        @(negedge clk);
        chk("timeout pulse", timeout_err, 1);
        chk("timeout grant released", grant, 0);
        chk("timeout busy", busy, 0);
        #1;
        chk("timeout req1 ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        chk("timeout pulse one cycle", timeout_err, 0);
        chk("timeout req1 tx_data", tx_data, 8'hCD);
        chk("timeout req1 grant", grant, 2'b10);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("timeout req1 done", busy, 0);
`endif

        // Randomized packets on both requesters against a packet-level model.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            len[k]  = 0;
            head[k] = 0;
            for (int p = 0; p < 6; p++) begin
                pl = $urandom_range(1, 4);
                for (int b = 0; b < pl; b++) begin
                    rd[k][len[k]] = 8'($urandom);
                    rl[k][len[k]] = (b == pl - 1);
                    len[k]++;
                end
            end
        end
        vld = 2'b00; open_k = -1; last_owner = 1; exp_src = 0; done_cnt = 0;
        busy_byte = 0; wr_due = 0; idle_due = 0; exp_last = 0; finished = 0;
        exp_data = 8'h00;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            @(negedge clk);
            chk("rand tx_wr", tx_wr, wr_due);
            if (wr_due) begin
                chk("rand tx_data", tx_data, exp_data);
                chk("rand grant", grant, oh(exp_src));
                done_cnt = $urandom_range(2, 9);
            end
            if (idle_due) chk("rand idle after packet", {busy, grant}, 0);
            chk("rand timeout_err", timeout_err, 0);
            wr_due   = 0;
            idle_due = 0;
            tx_done  = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) tx_done = 1'b1;
            end
            for (int k = 0; k < 2; k++)
                if (!vld[k] && head[k] < len[k] && $urandom_range(0, 2) != 0) vld[k] = 1'b1;
            req0_valid = vld[0];
            req1_valid = vld[1];
            if (vld[0]) begin req0_data = rd[0][head[0]]; req0_last = rl[0][head[0]]; end
            if (vld[1]) begin req1_data = rd[1][head[1]]; req1_last = rl[1][head[1]]; end
            #1;
            if (busy_byte)        exp_rdy = 2'b00;
            else if (open_k >= 0) exp_rdy = vld[open_k] ? oh(open_k) : 2'b00;
            else if (vld == 2'b11) exp_rdy = oh(1 - last_owner);
            else                  exp_rdy = vld;
            rdy = {req1_ready, req0_ready};
            chk("rand ready", rdy, exp_rdy);
            if (tx_done) begin
                busy_byte = 0;
                if (exp_last) begin
                    last_owner = open_k;
                    open_k     = -1;
                    idle_due   = 1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (vld[k] && rdy[k]) begin
                    exp_data  = rd[k][head[k]];
                    exp_last  = rl[k][head[k]];
                    exp_src   = k;
                    open_k    = k;
                    busy_byte = 1;
                    wr_due    = 1;
                    head[k]++;
                    vld[k]    = 1'b0;
                end
            end
            if (head[0] == len[0] && head[1] == len[1] && !busy_byte && open_k < 0
                && !wr_due && !idle_due) finished = 1;
        end
        chk("rand all packets completed", finished, 1);
        clear_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
